// File: rtl/avalon_pio_responder_if.sv
// Avalon-MM slave bundle carrying the request, response and stall signals of the PIO responder.
interface avalon_pio_responder_if #(
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] avs_address;
  logic [3:0]            avs_byteenable;
  logic                  avs_read;
  logic                  avs_write;
  logic [31:0]           avs_writedata;
  logic [31:0]           avs_readdata;
  logic                  avs_waitrequest;
  logic                  avs_readdatavalid;

  modport master (
    output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest, avs_readdatavalid
  );
endinterface

// File: rtl/avalon_pio_responder.sv
// Avalon-MM PIO responder: output register, synchronised inputs with rising-edge capture,
// interrupt mask, programmable wait states and a fixed-latency read pipeline.
module avalon_pio_responder #(
  parameter int ADDR_WIDTH   = 3,
  parameter int IN_WIDTH     = 8,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_STATES  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  avalon_pio_responder_if.slave         avs,
  input  logic [IN_WIDTH-1:0]           pio_in,
  output logic [31:0]                   pio_out,
  output logic                          ins_irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_OUT = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_IN  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_MASK = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_EDGE_CAP = ADDR_WIDTH'(3);
  localparam logic [2:0]            WAIT_MAX      = 3'(WAIT_STATES);

  logic [31:0]         data_out;
  logic [IN_WIDTH-1:0] irq_mask;
  logic [IN_WIDTH-1:0] edge_cap;
  logic [IN_WIDTH-1:0] sync_1;
  logic [IN_WIDTH-1:0] sync_2;
  logic [IN_WIDTH-1:0] sync_prev;
  logic [2:0]          wait_cnt;
  logic                irq_q;

  logic [READ_LATENCY-1:0] rd_vld;
  logic [31:0]             rd_data [READ_LATENCY];

  logic                req;
  logic                accept;
  logic                wr_acc;
  logic                rd_acc;
  logic [31:0]         rd_value;
  logic [IN_WIDTH-1:0] cap_clear;
  logic [IN_WIDTH-1:0] edge_rise;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign req                 = avs.avs_read | avs.avs_write;
  assign avs.avs_waitrequest = req && (wait_cnt != WAIT_MAX);
  assign accept              = req && !avs.avs_waitrequest;
  // A simultaneous read and write is serviced as a write only.
  assign wr_acc              = accept && avs.avs_write;
  assign rd_acc              = accept && avs.avs_read && !avs.avs_write;
  assign edge_rise           = sync_2 & ~sync_prev;

  always_comb begin
    rd_value = 32'h0;
    case (avs.avs_address)
      ADDR_DATA_OUT: rd_value = data_out;
      ADDR_DATA_IN:  rd_value = 32'(sync_2);
      ADDR_IRQ_MASK: rd_value = 32'(irq_mask);
      ADDR_EDGE_CAP: rd_value = 32'(edge_cap);
      default:       rd_value = 32'h0;
    endcase
  end

  always_comb begin
    cap_clear = '0;
    if (wr_acc && (avs.avs_address == ADDR_EDGE_CAP)) begin
      cap_clear = IN_WIDTH'(merge_bytes(32'h0, avs.avs_writedata, avs.avs_byteenable));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out  <= 32'h0;
      irq_mask  <= '0;
      edge_cap  <= '0;
      sync_1    <= '0;
      sync_2    <= '0;
      sync_prev <= '0;
      wait_cnt  <= 3'd0;
      irq_q     <= 1'b0;
      rd_vld    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_data[i] <= 32'h0;
    end else begin
      sync_1    <= pio_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      wait_cnt  <= avs.avs_waitrequest ? wait_cnt + 3'd1 : 3'd0;

      if (wr_acc) begin
        case (avs.avs_address)
          ADDR_DATA_OUT: data_out <= merge_bytes(data_out, avs.avs_writedata, avs.avs_byteenable);
          ADDR_IRQ_MASK: irq_mask <= IN_WIDTH'(merge_bytes(32'(irq_mask), avs.avs_writedata,
                                                           avs.avs_byteenable));
          default: ;
        endcase
      end

      // A fresh edge outranks a same-cycle write-1-to-clear.
      edge_cap <= (edge_cap & ~cap_clear) | edge_rise;
      irq_q    <= |(edge_cap & irq_mask);

      // Empty slots carry zero so readdata is zero whenever readdatavalid is low.
      rd_vld[0]  <= rd_acc;
      rd_data[0] <= rd_acc ? rd_value : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_data[i] <= rd_data[i-1];
      end
    end
  end

  assign pio_out               = data_out;
  assign ins_irq               = irq_q;
  assign avs.avs_readdatavalid = rd_vld[READ_LATENCY-1];
  assign avs.avs_readdata      = rd_data[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_pio_responder.sv
// Bench for avalon_pio_responder: two instances (no wait states / three wait states) against a
// transaction-level model, plus directed sequences with literal expectations.
module tb_avalon_pio_responder;
  localparam int AW    = 3;
  localparam int INW   = 8;
  localparam int WS_A  = 0;
  localparam int LAT_A = 2;
  localparam int WS_B  = 3;
  localparam int LAT_B = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [INW-1:0] pio_in = 8'h00;
  logic           rd_v   [2] = '{1'b0, 1'b0};
  logic           wr_v   [2] = '{1'b0, 1'b0};
  logic [AW-1:0]  addr_v [2] = '{3'd0, 3'd0};
  logic [3:0]     be_v   [2] = '{4'h0, 4'h0};
  logic [31:0]    wd_v   [2] = '{32'h0, 32'h0};

  avalon_pio_responder_if #(.ADDR_WIDTH(AW)) bus0 ();
  avalon_pio_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  assign bus0.avs_address    = addr_v[0];
  assign bus0.avs_byteenable = be_v[0];
  assign bus0.avs_read       = rd_v[0];
  assign bus0.avs_write      = wr_v[0];
  assign bus0.avs_writedata  = wd_v[0];
  assign bus1.avs_address    = addr_v[1];
  assign bus1.avs_byteenable = be_v[1];
  assign bus1.avs_read       = rd_v[1];
  assign bus1.avs_write      = wr_v[1];
  assign bus1.avs_writedata  = wd_v[1];

  logic [31:0] pio_out_a, pio_out_b;
  logic        irq_a, irq_b;

  avalon_pio_responder #(.ADDR_WIDTH(AW), .IN_WIDTH(INW), .READ_LATENCY(LAT_A), .WAIT_STATES(WS_A))
    dut_a (.clock(clock), .reset(reset), .avs(bus0), .pio_in(pio_in), .pio_out(pio_out_a), .ins_irq(irq_a));
  avalon_pio_responder #(.ADDR_WIDTH(AW), .IN_WIDTH(INW), .READ_LATENCY(LAT_B), .WAIT_STATES(WS_B))
    dut_b (.clock(clock), .reset(reset), .avs(bus1), .pio_in(pio_in), .pio_out(pio_out_b), .ins_irq(irq_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic int ws_of(int k);  return (k == 0) ? WS_A : WS_B;  endfunction
  function automatic int lat_of(int k); return (k == 0) ? LAT_A : LAT_B; endfunction
  function automatic logic get_wreq(int k); return (k == 0) ? bus0.avs_waitrequest : bus1.avs_waitrequest; endfunction
  function automatic logic get_rdv(int k); return (k == 0) ? bus0.avs_readdatavalid : bus1.avs_readdatavalid; endfunction
  function automatic logic [31:0] get_rdd(int k); return (k == 0) ? bus0.avs_readdata : bus1.avs_readdata; endfunction
  function automatic logic [31:0] get_pout(int k); return (k == 0) ? pio_out_a : pio_out_b; endfunction
  function automatic logic get_irq(int k); return (k == 0) ? irq_a : irq_b; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]    m_out  [2];
  logic [INW-1:0] m_mask [2];
  logic [INW-1:0] m_cap  [2];
  logic           m_irq  [2];
  int             m_wait [2];
  logic [INW-1:0] hist   [3];   // pio_in as sampled at the last three edges, newest first
  rsp_t           q0 [$];
  rsp_t           q1 [$];

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_value(input int k, input logic [AW-1:0] a);
    case (a)
      3'd0:    return m_out[k];
      3'd1:    return {24'h0, hist[1]};
      3'd2:    return {24'h0, m_mask[k]};
      3'd3:    return {24'h0, m_cap[k]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic front_due(input int k, output logic [31:0] d);
    d = 32'h0;
    if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin d = q0[0].data; return 1'b1; end
    if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin d = q1[0].data; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [INW-1:0] rising, clr;
    logic           req, stall;
    logic [31:0]    w;
    rsp_t           r;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] = 32'h0; m_mask[k] = '0; m_cap[k] = '0; m_irq[k] = 1'b0; m_wait[k] = 0;
      end
      q0.delete();
      q1.delete();
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      rising = hist[1] & ~hist[2];
      for (int k = 0; k < 2; k++) begin
        m_irq[k]  = |(m_cap[k] & m_mask[k]);
        req       = rd_v[k] | wr_v[k];
        stall     = req && (m_wait[k] != ws_of(k));
        m_wait[k] = stall ? m_wait[k] + 1 : 0;
        clr       = '0;
        if (req && !stall) begin
          if (wr_v[k]) begin
            w = 32'h0;
            case (addr_v[k])
              3'd0: m_out[k] = lanes(m_out[k], wd_v[k], be_v[k]);
              3'd2: begin w = lanes({24'h0, m_mask[k]}, wd_v[k], be_v[k]); m_mask[k] = w[7:0]; end
              3'd3: begin w = lanes(32'h0, wd_v[k], be_v[k]); clr = w[7:0]; end
              default: ;
            endcase
          end else begin
            r.due  = cyc + lat_of(k);
            r.data = reg_value(k, addr_v[k]);
            if (k == 0) q0.push_back(r); else q1.push_back(r);
          end
        end
        m_cap[k] = (m_cap[k] & ~clr) | rising;
      end
      if (q0.size() > 0 && q0[0].due == cyc) q0.pop_front();
      if (q1.size() > 0 && q1[0].due == cyc) q1.pop_front();
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pio_in;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  logic [31:0] cmp_d;
  logic        cmp_v;
  initial forever begin
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      cmp_v = front_due(k, cmp_d);
      check($sformatf("model_waitrequest%0d", k), 32'(get_wreq(k)),
            32'((rd_v[k] | wr_v[k]) && (m_wait[k] != ws_of(k))));
      check($sformatf("model_readdatavalid%0d", k), 32'(get_rdv(k)), 32'(cmp_v));
      check($sformatf("model_readdata%0d", k), get_rdd(k), cmp_d);
      check($sformatf("model_pio_out%0d", k), get_pout(k), m_out[k]);
      check($sformatf("model_ins_irq%0d", k), 32'(get_irq(k)), 32'(m_irq[k]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int k, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    rd_v[k] = rd; wr_v[k] = wr; addr_v[k] = a; be_v[k] = be; wd_v[k] = wd;
  endtask

  task automatic idle(input int k);
    rd_v[k] = 1'b0; wr_v[k] = 1'b0;
  endtask

  task automatic do_access(input int k, input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [3:0] be, input logic [31:0] wd, output int acc);
    logic done;
    done = 1'b0;
    acc  = -1;
    drive(k, rd, wr, a, be, wd);
    for (int n = 0; n < 16 && !done; n++) begin
      @(negedge clock);
      if (!get_wreq(k)) begin acc = cyc; done = 1'b1; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout bus%0d: got no acceptance, expected one within 16 cycles", k);
    end
    @(posedge clock);
    #1;
    idle(k);
  endtask

  // ---------------- directed then random ----------------
  initial begin
    int          acc, c;
    logic [31:0] exp_rd [5];

    pio_in = 8'h5A;
    reset  = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    @(negedge clock);
    check("reset_pio_out", pio_out_a, 32'h0);
    check("reset_ins_irq", 32'(irq_a), 32'h0);
    check("reset_readdatavalid", 32'(bus0.avs_readdatavalid), 32'h0);
    check("reset_readdata", bus0.avs_readdata, 32'h0);
    repeat (5) step();

    do_access(0, 1'b0, 1'b1, 3'd0, 4'hF, 32'hDEADBEEF, acc);
    @(negedge clock);
    check("write_full_word", pio_out_a, 32'hDEADBEEF);
    step();
    do_access(0, 1'b1, 1'b0, 3'd0, 4'hF, 32'h0, acc);
    @(negedge clock);
    check("read_not_early", 32'(bus0.avs_readdatavalid), 32'h0);
    @(negedge clock);
    check("read_latency2_valid", 32'(bus0.avs_readdatavalid), 32'h1);
    check("read_latency2_data", bus0.avs_readdata, 32'hDEADBEEF);
    step();

    do_access(0, 1'b0, 1'b1, 3'd0, 4'hF, 32'h0, acc);
    do_access(0, 1'b0, 1'b1, 3'd0, 4'h5, 32'hAABBCCDD, acc);
    @(negedge clock);
    check("write_byte_lanes", pio_out_a, 32'h00BB00DD);
    step();

    drive(1, 1'b1, 1'b0, 3'd1, 4'hF, 32'h0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("wait_state_%0d", i), 32'(bus1.avs_waitrequest), (i < 3) ? 32'h1 : 32'h0);
      if (i == 3) acc = cyc;
    end
    @(posedge clock);
    #1;
    idle(1);
    @(negedge clock);
    check("ws_read_gap1", 32'(bus1.avs_readdatavalid), 32'h0);
    @(negedge clock);
    check("ws_read_gap2", 32'(bus1.avs_readdatavalid), 32'h0);
    @(negedge clock);
    check("ws_read_valid", 32'(bus1.avs_readdatavalid), 32'h1);
    check("ws_read_data_in", bus1.avs_readdata, 32'h0000005A);
    step();

    do_access(0, 1'b0, 1'b1, 3'd3, 4'hF, 32'hFF, acc);
    do_access(0, 1'b0, 1'b1, 3'd2, 4'hF, 32'h01, acc);
    c = cyc;
    pio_in = 8'h5B;
    repeat (3) step();
    drive(0, 1'b1, 1'b0, 3'd3, 4'hF, 32'h0);
    @(negedge clock);
    check("irq_before", 32'(irq_a), 32'h0);
    @(posedge clock);
    #1;
    idle(0);
    @(negedge clock);
    check("irq_after_edge", 32'(irq_a), 32'h1);
    @(negedge clock);
    check("edge_cap_valid", 32'(bus0.avs_readdatavalid), 32'h1);
    check("edge_cap_value", bus0.avs_readdata, 32'h01);
    step();
    do_access(0, 1'b0, 1'b1, 3'd3, 4'hF, 32'h01, acc);
    @(negedge clock);
    check("irq_held_after_clear", 32'(irq_a), 32'h1);
    @(negedge clock);
    check("irq_cleared", 32'(irq_a), 32'h0);
    step();

    exp_rd[0] = 32'h00BB00DD; exp_rd[1] = 32'h5B; exp_rd[2] = 32'h01;
    exp_rd[3] = 32'h00;       exp_rd[4] = 32'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(0, 1'b1, 1'b0, (i == 4) ? 3'd5 : 3'(i), 4'hF, 32'h0);
      else idle(0);
      @(negedge clock);
      if (i >= 2 && i < 7) begin
        check($sformatf("burst_valid_%0d", i - 2), 32'(bus0.avs_readdatavalid), 32'h1);
        check($sformatf("burst_data_%0d", i - 2), bus0.avs_readdata, exp_rd[i-2]);
      end else begin
        check($sformatf("burst_idle_%0d", i), 32'(bus0.avs_readdatavalid), 32'h0);
      end
      step();
    end

    drive(0, 1'b1, 1'b0, 3'd0, 4'hF, 32'h0);
    step();
    step();
    reset = 1'b0;
    idle(0);
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("flush_readdatavalid", 32'(bus0.avs_readdatavalid), 32'h0);
      check("flush_readdata", bus0.avs_readdata, 32'h0);
      check("flush_pio_out", pio_out_a, 32'h0);
      check("flush_ins_irq", 32'(irq_a), 32'h0);
      step();
    end

    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 2; k++) begin
        int op;
        if (k == 1 && get_wreq(1) && $urandom_range(3) != 0) continue;
        op = int'($urandom_range(7));
        rd_v[k]   = (op <= 2) || (op == 6);
        wr_v[k]   = (op >= 3) && (op <= 6);
        addr_v[k] = 3'($urandom_range(7));
        be_v[k]   = 4'($urandom_range(15));
        wd_v[k]   = $urandom;
      end
      if ($urandom_range(7) == 0) pio_in = 8'($urandom);
      reset = ($urandom_range(299) != 0);
      step();
    end

    reset = 1'b1;
    idle(0);
    idle(1);
    repeat (6) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_pio_responder.md
AVALON_PIO_RESPONDER -- requirements
Module: avalon_pio_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, word-address width of the slave port.
REQ-002 SHALL have parameter IN_WIDTH, default 8, number of input pins, range 1..32.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from read acceptance to readdatavalid, range 1..4.
REQ-004 SHALL have parameter WAIT_STATES, default 0, waitrequest cycles inserted before each access is accepted, range 0..7.
REQ-005 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port avs_address  input  ADDR_WIDTH  word address.
REQ-008 SHALL have port avs_byteenable  input  4  byte lanes for writes.
REQ-009 SHALL have ports avs_read, avs_write  input  1 each  access requests.
REQ-010 SHALL have port avs_writedata  input  32  write data.
REQ-011 SHALL have port avs_readdata  output  32  read data, meaningful only with readdatavalid.
REQ-012 SHALL have port avs_waitrequest  output  1  stall, combinational from internal state and request inputs.
REQ-013 SHALL have port avs_readdatavalid  output  1  one-cycle read-response strobe.
REQ-014 SHALL have port pio_in  input  IN_WIDTH  asynchronous input pins.
REQ-015 SHALL have port pio_out  output  32  registered output pins.
REQ-016 SHALL have port ins_irq  output  1  level interrupt, registered.

Function
REQ-017 Register map (word address): 0 DATA_OUT RW; 1 DATA_IN RO; 2 IRQ_MASK RW (IN_WIDTH bits); 3 EDGE_CAP read / write-1-to-clear; all others read 0, writes ignored.
REQ-018 pio_in SHALL pass a 2-flop synchroniser; DATA_IN is the second stage, zero-extended to 32 bits.
REQ-019 A rising edge (sync stage2 0 -> 1 between consecutive cycles) on bit i SHALL set EDGE_CAP[i] the following cycle.
REQ-020 Same-cycle write-1-clear and new edge on one bit: set wins.
REQ-021 Wait counter (0..WAIT_STATES): waitrequest = (read|write) && counter != WAIT_STATES; counter increments while waitrequest, returns to 0 on acceptance or if read and write both drop.
REQ-022 WAIT_STATES=0: waitrequest permanently 0, one access accepted per cycle.
REQ-023 Access accepted when (read|write) && !waitrequest; read and write both high SHALL be treated as write only.
REQ-024 Accepted write SHALL update only byte lanes with byteenable set, visible the next cycle.
REQ-025 Accepted read SHALL sample register value at acceptance cycle; readdatavalid high exactly READ_LATENCY cycles later for one cycle with that data.
REQ-026 Read pipeline SHALL hold READ_LATENCY in-flight reads; back-to-back reads return in order, one per cycle, no bubbles.
REQ-027 avs_readdata SHALL be 0 whenever readdatavalid is 0.
REQ-028 ins_irq SHALL be registered |(EDGE_CAP & IRQ_MASK), one cycle after either changes.
REQ-029 Reading EDGE_CAP SHALL NOT clear it.

Reset
REQ-030 While reset=0 at a clock edge: DATA_OUT, IRQ_MASK, EDGE_CAP, synchroniser, wait counter, read pipeline all 0; pio_out=0, ins_irq=0, readdatavalid=0, readdata=0.
REQ-031 In-flight reads at reset SHALL be discarded: no readdatavalid after reset releases.
REQ-032 First cycle after reset release SHALL NOT detect an edge from synchroniser reset value alone unless pio_in is 1 at release (then edge detected after 2-flop delay, per REQ-019).

Verification
REQ-033 WAIT_STATES=0, LATENCY=2: write 0xDEADBEEF addr 0, be=1111 -> pio_out=0xDEADBEEF next cycle; read addr 0 at cycle t -> readdatavalid at t+2, readdata 0xDEADBEEF.
REQ-034 DATA_OUT=0x00000000, write 0xAABBCCDD be=0101 -> pio_out=0x00BB00DD.
REQ-035 WAIT_STATES=3: hold read addr 1 -> waitrequest high 3 cycles, accepted 4th; readdatavalid LATENCY cycles after acceptance.
REQ-036 IRQ_MASK=0x01, pio_in[0] 0->1 -> EDGE_CAP=0x01 after 3 cycles, ins_irq=1 one cycle later; write 0x01 addr 3 -> ins_irq=0 two cycles after acceptance.
REQ-037 Reads of addrs 0,1,2,3 on 4 consecutive cycles -> 4 consecutive readdatavalid pulses, data in order; addr 5 read -> 0.
REQ-038 Reset asserted with 2 reads in flight -> no readdatavalid after release; all outputs 0.
